// File: rtl/pipe_scoreboard_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_scoreboard_if : ID/WB/branch inputs and pipeline-control outputs. Rev 1.0
// ----------------------------------------------------------------------------
interface pipe_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             i_id_vld;
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic [4:0]       i_id_rd;
  logic             i_id_wr_en;
  logic [4:0]       i_wb_rd;
  logic             i_wb_wr_en;
  logic             i_br_taken;
  logic             o_pc_en;
  logic             o_pass_s1;
  logic             o_pass_s2;
  logic             o_clr_s1;
  logic             o_clr_s2;
  logic             o_clr_s3;
  logic [31:0]      o_busy_map;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;
  logic [1:0]       o_state;

  modport master (
    output i_id_vld, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_wr_en, i_wb_rd, i_wb_wr_en, i_br_taken,
    input  o_pc_en, o_pass_s1, o_pass_s2, o_clr_s1, o_clr_s2, o_clr_s3,
           o_busy_map, o_stall_cnt, o_flush_cnt, o_state
  );

  modport slave (
    input  i_id_vld, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_wr_en, i_wb_rd, i_wb_wr_en, i_br_taken,
    output o_pc_en, o_pass_s1, o_pass_s2, o_clr_s1, o_clr_s2, o_clr_s3,
           o_busy_map, o_stall_cnt, o_flush_cnt, o_state
  );
endinterface
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_scoreboard : register busy-bit scoreboard with stall/flush control. Rev 1.0
// ----------------------------------------------------------------------------
module pipe_scoreboard #(
  parameter int CNT_W     = 16,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  pipe_scoreboard_if.slave  bus
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_FLUSH = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic             ex_vld_q, ex_vld_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [31:0]      wb_clr_vec;
  logic [31:0]      busy_vis;
  logic             hz_rs1, hz_rs2, hz_rd, hazard;
  logic             issue, stall_ev, flush_ev, id_writes;
  logic             pc_en, pass_s1, pass_s2, clr_s1, clr_s2, clr_s3;

  always_comb begin
    wb_clr_vec = '0;
    if (bus.i_wb_wr_en && (bus.i_wb_rd != 5'd0)) begin
      wb_clr_vec[bus.i_wb_rd] = 1'b1;
    end
  end

  // With bypass, a bit retiring this cycle is already invisible to ID.
  always_comb begin
    busy_vis    = WB_BYPASS ? (busy_q & ~wb_clr_vec) : busy_q;
    busy_vis[0] = 1'b0;
  end

  always_comb begin
    hz_rs1    = bus.i_id_use_rs1 && (bus.i_id_rs1 != 5'd0) && busy_vis[bus.i_id_rs1];
    hz_rs2    = bus.i_id_use_rs2 && (bus.i_id_rs2 != 5'd0) && busy_vis[bus.i_id_rs2];
    hz_rd     = bus.i_id_wr_en   && (bus.i_id_rd  != 5'd0) && busy_vis[bus.i_id_rd];
    hazard    = bus.i_id_vld && (hz_rs1 || hz_rs2 || hz_rd);
    id_writes = bus.i_id_wr_en && (bus.i_id_rd != 5'd0);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    pass_s1  = 1'b0;
    pass_s2  = 1'b0;
    clr_s1   = 1'b1;
    clr_s2   = 1'b1;
    clr_s3   = 1'b1;
    issue    = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    case (state_q)
      S_HOLD: begin
        state_d = S_RUN;
      end
      default: begin
        if (bus.i_br_taken) begin
          pc_en    = 1'b1;
          pass_s1  = 1'b1;
          pass_s2  = 1'b1;
          flush_ev = 1'b1;
          state_d  = S_FLUSH;
        end else if (state_q == S_FLUSH) begin
          // Slot in ID was squashed by the redirect, so nothing issues.
          pc_en   = 1'b1;
          pass_s1 = 1'b1;
          pass_s2 = 1'b1;
          clr_s1  = 1'b0;
          clr_s3  = 1'b0;
          state_d = S_RUN;
        end else if (hazard) begin
          pass_s2  = 1'b1;
          clr_s1   = 1'b0;
          clr_s3   = 1'b0;
          stall_ev = 1'b1;
          state_d  = S_STALL;
        end else begin
          pc_en   = 1'b1;
          pass_s1 = 1'b1;
          pass_s2 = 1'b1;
          clr_s1  = 1'b0;
          clr_s2  = 1'b0;
          clr_s3  = 1'b0;
          issue   = bus.i_id_vld;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // Set after clear so an issuing writer wins over a same-register writeback.
  always_comb begin
    busy_d = busy_q & ~wb_clr_vec;
    if (flush_ev && ex_vld_q) begin
      busy_d[ex_rd_q] = 1'b0;
    end
    if (issue && id_writes) begin
      busy_d[bus.i_id_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // The EX tag only needs to name a real writer; anything else is a bubble.
  always_comb begin
    ex_vld_d = issue && id_writes;
    ex_rd_d  = bus.i_id_rd;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      busy_q      <= '0;
      ex_vld_q    <= 1'b0;
      ex_rd_q     <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      ex_vld_q    <= ex_vld_d;
      ex_rd_q     <= ex_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.o_pc_en     = pc_en;
  assign bus.o_pass_s1   = pass_s1;
  assign bus.o_pass_s2   = pass_s2;
  assign bus.o_clr_s1    = clr_s1;
  assign bus.o_clr_s2    = clr_s2;
  assign bus.o_clr_s3    = clr_s3;
  assign bus.o_busy_map  = {busy_q[31:1], 1'b0};
  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;
  assign bus.o_state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_scoreboard : bypass/no-bypass instances against a reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_scoreboard;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_vld, u1, u2, wr, wbw, br;
  logic [4:0] rs1, rs2, rd, wbrd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_scoreboard_if #(.CNT_W(CNT_W)) if_a ();
  pipe_scoreboard_if #(.CNT_W(CNT_W)) if_b ();

  assign if_a.i_id_vld = id_vld;  assign if_b.i_id_vld = id_vld;
  assign if_a.i_id_rs1 = rs1;     assign if_b.i_id_rs1 = rs1;
  assign if_a.i_id_rs2 = rs2;     assign if_b.i_id_rs2 = rs2;
  assign if_a.i_id_use_rs1 = u1;  assign if_b.i_id_use_rs1 = u1;
  assign if_a.i_id_use_rs2 = u2;  assign if_b.i_id_use_rs2 = u2;
  assign if_a.i_id_rd = rd;       assign if_b.i_id_rd = rd;
  assign if_a.i_id_wr_en = wr;    assign if_b.i_id_wr_en = wr;
  assign if_a.i_wb_rd = wbrd;     assign if_b.i_wb_rd = wbrd;
  assign if_a.i_wb_wr_en = wbw;   assign if_b.i_wb_wr_en = wbw;
  assign if_a.i_br_taken = br;    assign if_b.i_br_taken = br;

  pipe_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b0)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .bus(if_a)
  );
  pipe_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b1)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .bus(if_b)
  );

  // Reference model: index 0 = no bypass, index 1 = bypass.
  bit [31:0] m_busy  [2];
  int        m_state [2];
  int        m_ex    [2];
  int        m_stall [2];
  int        m_flush [2];
  int        e_next  [2];
  bit        e_issue [2];
  bit        e_stall [2];
  bit        e_flush [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_busy[b]  = '0;
      m_state[b] = 0;
      m_ex[b]    = -1;
      m_stall[b] = 0;
      m_flush[b] = 0;
    end
  endtask

  function automatic bit seen(input int b, input logic [4:0] r);
    bit retiring;
    retiring = (b == 1) && wbw && (wbrd == r);
    return (r != 5'd0) && m_busy[b][r] && !retiring;
  endfunction

  function automatic logic [5:0] dut_ctl(input int b);
    if (b == 0)
      return {if_a.o_pc_en, if_a.o_pass_s1, if_a.o_pass_s2, if_a.o_clr_s1, if_a.o_clr_s2, if_a.o_clr_s3};
    return {if_b.o_pc_en, if_b.o_pass_s1, if_b.o_pass_s2, if_b.o_clr_s1, if_b.o_clr_s2, if_b.o_clr_s3};
  endfunction

  task automatic eval_and_check(input int b);
    bit         hz;
    logic [5:0] ctl;  // {pc_en, pass_s1, pass_s2, clr_s1, clr_s2, clr_s3}
    hz = id_vld && ((u1 && seen(b, rs1)) || (u2 && seen(b, rs2)) || (wr && seen(b, rd)));
    e_issue[b] = 1'b0;
    e_stall[b] = 1'b0;
    e_flush[b] = 1'b0;
    if (m_state[b] == 0) begin
      ctl = 6'b000111; e_next[b] = 1;
    end else if (br) begin
      ctl = 6'b111111; e_next[b] = 3; e_flush[b] = 1'b1;
    end else if (m_state[b] == 3) begin
      ctl = 6'b111010; e_next[b] = 1;
    end else if (hz) begin
      ctl = 6'b001010; e_next[b] = 2; e_stall[b] = 1'b1;
    end else begin
      ctl = 6'b111000; e_next[b] = 1; e_issue[b] = id_vld;
    end
    chk($sformatf("ctl%0d", b), 32'(dut_ctl(b)), 32'(ctl));
    chk($sformatf("busy%0d", b), (b == 0) ? if_a.o_busy_map : if_b.o_busy_map, m_busy[b]);
    chk($sformatf("state%0d", b), 32'((b == 0) ? if_a.o_state : if_b.o_state), 32'(m_state[b]));
    chk($sformatf("stall_cnt%0d", b), 32'((b == 0) ? if_a.o_stall_cnt : if_b.o_stall_cnt), 32'(m_stall[b]));
    chk($sformatf("flush_cnt%0d", b), 32'((b == 0) ? if_a.o_flush_cnt : if_b.o_flush_cnt), 32'(m_flush[b]));
  endtask

  task automatic model_update(input int b);
    if (wbw && wbrd != 5'd0) m_busy[b][wbrd] = 1'b0;
    if (e_flush[b] && m_ex[b] > 0) m_busy[b][m_ex[b]] = 1'b0;
    if (e_issue[b] && wr && rd != 5'd0) begin
      m_busy[b][rd] = 1'b1;
      m_ex[b] = int'(rd);
    end else begin
      m_ex[b] = -1;
    end
    if (e_stall[b] && m_stall[b] < CMAX) m_stall[b]++;
    if (e_flush[b] && m_flush[b] < CMAX) m_flush[b]++;
    m_state[b] = e_next[b];
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic a1, input logic a2, input logic [4:0] d, input logic w,
                     input logic [4:0] wd, input logic ww, input logic b);
    id_vld = v; rs1 = r1; rs2 = r2; u1 = a1; u2 = a2;
    rd = d; wr = w; wbrd = wd; wbw = ww; br = b;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    #1;
    for (int b = 0; b < 2; b++) eval_and_check(b);
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (!rst_n) model_reset();
      else model_update(b);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();
    chk("hold_to_run", 32'(if_a.o_state), 32'd1);
    step();

    // RAW stall without bypass until the edge after writeback of x5.
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); step();
    #1;
    chk("s030_state", 32'(if_a.o_state), 32'd2);
    chk("s030_pc_en", 32'(if_a.o_pc_en), 32'd0);
    drv(1, 5, 0, 1, 0, 0, 0, 5, 1, 0); step();
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("s030_issue", 32'(if_a.o_pass_s1), 32'd1);
    step();
    idle(); step();

    // Bypass instance sees a same-cycle writeback as free.
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drv(1, 5, 0, 1, 0, 0, 0, 5, 1, 0);
    #1;
    chk("s031_no_stall", 32'(if_b.o_pc_en), 32'd1);
    chk("s031_a_stalls", 32'(if_a.o_pc_en), 32'd0);
    step();
    idle(); step();

    // Branch squashes the EX writer of x7.
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("s032_clr", 32'({if_a.o_clr_s1, if_a.o_clr_s2, if_a.o_clr_s3}), 32'd7);
    step();
    chk("s032_busy7", 32'(if_a.o_busy_map[7]), 32'd0);
    chk("s032_flush_cnt", 32'(if_a.o_flush_cnt), 32'd1);
    chk("s032_flush_state", 32'(if_a.o_state), 32'd3);
    idle(); step();
    chk("s032_back_run", 32'(if_a.o_state), 32'd1);

    // x0 is never busy.
    drv(1, 0, 0, 1, 1, 0, 1, 0, 0, 0); step(); step();
    chk("s033_busy", if_a.o_busy_map, 32'd0);
    chk("s033_state", 32'(if_a.o_state), 32'd1);

    // Reset in the middle of a stall acts without a clock edge.
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step();
    drv(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); step();
    chk("s035_busy3", 32'(if_a.o_busy_map[3]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s035_async_busy", if_a.o_busy_map, 32'd0);
    chk("s035_async_state", 32'(if_a.o_state), 32'd0);
    model_reset();
    @(negedge clk);
    idle(); step();
    rst_n = 1'b1;
    step();
    chk("s035_run", 32'(if_a.o_state), 32'd1);

    // Saturate the stall counter.
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (CMAX + 4) step();
    chk("s034_sat_a", 32'(if_a.o_stall_cnt), 32'(CMAX));
    chk("s034_sat_b", 32'(if_b.o_stall_cnt), 32'(CMAX));
    drv(0, 0, 0, 0, 0, 0, 0, 5, 1, 0); step();
    idle(); step();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 11) == 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the stall and flush event counters.
REQ-002 The block SHALL have parameter WB_BYPASS, default 0; 1 means a register written back this cycle is readable in ID this cycle.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  reset, asynchronous assert, active-low.
REQ-005 i_id_vld  in  1  the ID-stage slot holds a real instruction.
REQ-006 i_id_rs1, i_id_rs2  in  5 each  ID source register addresses.
REQ-007 i_id_use_rs1, i_id_use_rs2  in  1 each  the ID instruction reads that source.
REQ-008 i_id_rd, i_id_wr_en  in  5/1  ID destination register and its write enable.
REQ-009 i_wb_rd, i_wb_wr_en  in  5/1  writeback destination register and its write enable.
REQ-010 i_br_taken  in  1  the MEM-stage instruction redirects the PC this cycle.
REQ-011 o_pc_en  out  1  PC register write enable.
REQ-012 o_pass_s1, o_pass_s2  out  1 each  load enables for the IF/ID and ID/EX pipeline registers.
REQ-013 o_clr_s1, o_clr_s2, o_clr_s3  out  1 each  synchronous clears (bubble insert) for the IF/ID, ID/EX and EX/MEM registers.
REQ-014 o_busy_map  out  32  scoreboard; bit n set means register xn has an in-flight writer.
REQ-015 o_stall_cnt, o_flush_cnt  out  CNT_W each  saturating event counters.
REQ-016 o_state  out  2  FSM state: 00 HOLD, 01 RUN, 10 STALL, 11 FLUSH.

Function
REQ-017 The scoreboard SHALL hold 32 busy bits; bit 0 SHALL read 0 at all times.
REQ-018 hazard = i_id_vld AND (use_rs1 AND busy[rs1], OR use_rs2 AND busy[rs2], OR i_id_wr_en AND busy[rd]), with the WAW term included; nonzero addresses only.
REQ-019 When WB_BYPASS=1, a busy bit being cleared by writeback in the current cycle SHALL NOT cause a hazard; when WB_BYPASS=0 it SHALL.
REQ-020 Issue occurs when i_id_vld=1, hazard=0, i_br_taken=0 and the state is RUN or STALL; on issue with i_id_wr_en=1 and rd!=0, busy[rd] SHALL be set at the next edge.
REQ-021 When i_wb_wr_en=1 and wb_rd!=0, busy[wb_rd] SHALL be cleared at the next edge; when the same register is set and cleared in one cycle, set SHALL win.
REQ-022 The block SHALL keep an EX tag (valid, rd) loaded from each issued instruction, and a bubble otherwise, to track the instruction in EX.
REQ-023 When hazard=1 and i_br_taken=0: o_pc_en=0, o_pass_s1=0, o_pass_s2=1, o_clr_s2=1 (bubble into EX), and the next state SHALL be STALL.
REQ-024 When i_br_taken=1: o_pc_en=1, o_clr_s1=o_clr_s2=o_clr_s3=1, no issue, and if the EX tag is valid its busy bit SHALL be cleared at the next edge; the next state SHALL be FLUSH. i_br_taken SHALL take priority over hazard.
REQ-025 FLUSH SHALL last one cycle; it SHALL behave as RUN with issue blocked (o_clr_s2=1), then return to RUN.
REQ-026 When the state is RUN with no hazard and no branch, all pass/enable outputs SHALL be 1 and all clears 0; STALL SHALL return to RUN in the first cycle the hazard clears.
REQ-027 o_stall_cnt SHALL increment by 1 per stall cycle and o_flush_cnt by 1 per i_br_taken cycle, each saturating at 2^CNT_W-1 with no wrap.

Reset
REQ-028 While i_reset=0: state HOLD, busy map 0, EX tag invalid, counters 0, o_pc_en=0, all pass outputs 0, all clears 1.
REQ-029 HOLD SHALL last exactly one cycle after reset deassertion, then go to RUN; a reset asserted mid-stall or mid-flush SHALL return to HOLD immediately.

Verification
REQ-030 Scenario: issue rd=5; next cycle ID reads rs1=5 (WB_BYPASS=0) -> stall (o_pc_en=0, o_clr_s2=1, state 10) until the edge after wb_rd=5, then issue.
REQ-031 Scenario: busy[5]=1 and wb_rd=5 in the same cycle ID reads x5, WB_BYPASS=1 -> no stall, issue that cycle.
REQ-032 Scenario: issue rd=7, then i_br_taken=1 while rd=7 is in EX -> o_clr_s1..s3=1, busy[7]=0 next cycle, o_flush_cnt=1, state 11 then 01.
REQ-033 Scenario: i_id_rd=0 with i_id_wr_en=1, and ID reads x0 -> no busy bit set and no stall.
REQ-034 Scenario: force 2^CNT_W+3 stall cycles -> o_stall_cnt holds at 2^CNT_W-1.
REQ-035 Scenario: assert i_reset=0 during STALL with busy[3]=1 -> o_busy_map=0 and o_state=00 without waiting for a clock edge; after release, one HOLD cycle, then 01.
